// File: rtl/traffic_phase_if.sv
// Detector/emergency inputs and signal-head outputs of the phase scheduler.
interface traffic_phase_if;
   logic       tick;
   logic [3:0] req;
   logic       emerg_valid;
   logic [1:0] emerg_dir;
   logic [2:0] light_n;
   logic [2:0] light_s;
   logic [2:0] light_e;
   logic [2:0] light_w;
   logic [1:0] phase_dir;
   logic [1:0] phase_state;

   modport master (
      output tick, req, emerg_valid, emerg_dir,
      input  light_n, light_s, light_e, light_w, phase_dir, phase_state
   );

   modport slave (
      input  tick, req, emerg_valid, emerg_dir,
      output light_n, light_s, light_e, light_w, phase_dir, phase_state
   );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin green-phase scheduler for a 4-approach intersection
// with emergency preemption and min/max green, yellow and all-red timing.
module traffic_phase_scheduler #(
   parameter int unsigned CW        = 4,
   parameter int unsigned GREEN_MIN = 4,
   parameter int unsigned GREEN_MAX = 12,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 2
) (
   input  logic             clk,
   input  logic             rst,
   traffic_phase_if.slave   bus
);

   localparam int unsigned TW = CW + 1;
   localparam logic [CW:0]   G_MIN  = TW'(GREEN_MIN);
   localparam logic [CW:0]   G_MAX  = TW'(GREEN_MAX);
   localparam logic [CW:0]   Y_T    = TW'(YELLOW_T);
   localparam logic [CW-1:0] G_SAT  = CW'(GREEN_MAX);
   localparam logic [CW-1:0] AR_SAT = CW'(ALLRED_T);

   localparam logic [2:0] L_GREEN  = 3'b001;
   localparam logic [2:0] L_YELLOW = 3'b010;
   localparam logic [2:0] L_RED    = 3'b100;

   typedef enum logic [1:0] {
      S_ALL_RED = 2'b00,
      S_GREEN   = 2'b01,
      S_YELLOW  = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   timer_q, timer_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [1:0]      dir_q, dir_d;
   logic [3:0][2:0] heads_q, heads_d;

   logic [CW:0]     timer_inc;
   logic            cand_vld;
   logic [1:0]      cand_dir;
   logic [1:0]      idx;
   logic            others;
   logic            hold;
   logic            preempt;

   assign timer_inc = TW'(timer_q) + TW'(1);
   assign others    = |(bus.req & ~(4'b0001 << dir_q));
   assign hold      = bus.emerg_valid && (bus.emerg_dir == dir_q);
   assign preempt   = bus.emerg_valid && (bus.emerg_dir != dir_q);

   // Arbitration: emergency wins outright; otherwise first request after the pointer, pointer last.
   always_comb begin
      cand_vld = 1'b0;
      cand_dir = ptr_q;
      idx      = '0;
      if (bus.emerg_valid) begin
         cand_vld = 1'b1;
         cand_dir = bus.emerg_dir;
      end else begin
         for (int i = 4; i >= 1; i--) begin
            idx = ptr_q + 2'(i);
            if (bus.req[idx]) begin
               cand_vld = 1'b1;
               cand_dir = idx;
            end
         end
      end
   end

   // Next-state, timer and registered-output decode.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      ptr_d   = ptr_q;
      dir_d   = dir_q;
      heads_d = {4{L_RED}};

      case (state_q)
         S_ALL_RED: begin
            if (timer_q == AR_SAT) begin
               if (cand_vld) begin
                  state_d = S_GREEN;
                  timer_d = '0;
                  dir_d   = cand_dir;
                  ptr_d   = cand_dir;
               end
            end else if (bus.tick) begin
               timer_d = CW'(timer_inc);
            end
         end
         S_GREEN: begin
            if (preempt) begin
               state_d = S_YELLOW;
               timer_d = '0;
            end else if (bus.tick) begin
               if (!hold && others &&
                   ((timer_inc == G_MAX) ||
                    ((timer_inc >= G_MIN) && !bus.req[dir_q]))) begin
                  state_d = S_YELLOW;
                  timer_d = '0;
               end else if (timer_q != G_SAT) begin
                  timer_d = CW'(timer_inc);
               end
            end
         end
         S_YELLOW: begin
            if (bus.tick) begin
               if (timer_inc == Y_T) begin
                  state_d = S_ALL_RED;
                  timer_d = '0;
               end else begin
                  timer_d = CW'(timer_inc);
               end
            end
         end
         default: begin
            state_d = S_ALL_RED;
            timer_d = '0;
         end
      endcase

      if (state_d == S_GREEN)       heads_d[dir_d] = L_GREEN;
      else if (state_d == S_YELLOW) heads_d[dir_d] = L_YELLOW;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_ALL_RED;
         timer_q <= '0;
         ptr_q   <= 2'd3;
         dir_q   <= 2'd0;
         heads_q <= {4{L_RED}};
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ptr_q   <= ptr_d;
         dir_q   <= dir_d;
         heads_q <= heads_d;
      end
   end

   assign bus.light_n     = heads_q[0];
   assign bus.light_s     = heads_q[1];
   assign bus.light_e     = heads_q[2];
   assign bus.light_w     = heads_q[3];
   assign bus.phase_dir   = dir_q;
   assign bus.phase_state = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: hand-computed light sequences.
module tb_traffic_phase_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   traffic_phase_if bus ();

   traffic_phase_scheduler #(
      .CW(4), .GREEN_MIN(4), .GREEN_MAX(12), .YELLOW_T(3), .ALLRED_T(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Heads packed {w,e,s,n}
   localparam logic [11:0] L_AR = 12'h924;
   logic [11:0] green_l [4];
   logic [11:0] yel_l   [4];
   logic [11:0] lights;
   assign lights = {bus.light_w, bus.light_e, bus.light_s, bus.light_n};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] r);
      bus.req = r;
      rst = 1'b1;
      run(2);
      rst = 1'b0;
   endtask

   initial begin
      green_l[0] = 12'h921; green_l[1] = 12'h90C; green_l[2] = 12'h864; green_l[3] = 12'h324;
      yel_l[0]   = 12'h922; yel_l[1]   = 12'h914; yel_l[2]   = 12'h8A4; yel_l[3]   = 12'h524;
      bus.tick = 1'b1;
      bus.req = 4'b0000;
      bus.emerg_valid = 1'b0;
      bus.emerg_dir = 2'd0;

      // 1: idle intersection stays all-red; settled all-red arbitrates without tick
      do_reset(4'b0000);
      check("t1_reset_lights", 32'(lights), 32'(L_AR));
      check("t1_reset_state", 32'(bus.phase_state), 32'd0);
      check("t1_reset_dir", 32'(bus.phase_dir), 32'd0);
      for (int c = 0; c < 20; c++) begin
         run(1);
         check("t1_idle_lights", 32'(lights), 32'(L_AR));
         check("t1_idle_state", 32'(bus.phase_state), 32'd0);
      end
      bus.tick = 1'b0;
      bus.req = 4'b0010;
      run(1);
      check("t1_notick_arb", 32'(lights), 32'(green_l[1]));
      check("t1_notick_dir", 32'(bus.phase_dir), 32'd1);
      bus.tick = 1'b1;

      // 2: single N request rests in green
      do_reset(4'b0001);
      run(2);
      check("t2_allred_done", 32'(lights), 32'(L_AR));
      run(1);
      check("t2_n_green", 32'(lights), 32'(green_l[0]));
      check("t2_state_green", 32'(bus.phase_state), 32'd1);
      run(30);
      check("t2_n_rest", 32'(lights), 32'(green_l[0]));

      // 3: all requests -> N,S,E,W,N with 12 green / 3 yellow / 3 all-red edges each
      do_reset(4'b1111);
      for (int c = 1; c <= 76; c++) begin
         logic [11:0] exp_l;
         logic [1:0]  exp_s;
         int off, k;
         run(1);
         if (c < 3) begin
            exp_l = L_AR; exp_s = 2'b00; k = 0;
         end else begin
            off = (c - 3) % 18;
            k   = ((c - 3) / 18) % 4;
            if (off < 12)      begin exp_l = green_l[k]; exp_s = 2'b01; end
            else if (off < 15) begin exp_l = yel_l[k];   exp_s = 2'b10; end
            else               begin exp_l = L_AR;       exp_s = 2'b00; end
         end
         check("t3_rr_lights", 32'(lights), 32'(exp_l));
         check("t3_rr_state", 32'(bus.phase_state), 32'(exp_s));
         if (exp_s != 2'b00) check("t3_rr_dir", 32'(bus.phase_dir), 32'(k));
      end

      // 4: gap-out at GREEN_MIN, timers frozen while tick=0
      do_reset(4'b0001);
      run(3);
      check("t4_n_green", 32'(lights), 32'(green_l[0]));
      bus.req = 4'b0100;
      bus.tick = 1'b0;
      run(10);
      check("t4_frozen", 32'(lights), 32'(green_l[0]));
      bus.tick = 1'b1;
      run(3);
      check("t4_before_min", 32'(lights), 32'(green_l[0]));
      run(1);
      check("t4_gapout_yellow", 32'(lights), 32'(yel_l[0]));
      run(2);
      check("t4_yellow_full", 32'(lights), 32'(yel_l[0]));
      run(1);
      check("t4_allred", 32'(lights), 32'(L_AR));
      run(2);
      check("t4_allred_end", 32'(lights), 32'(L_AR));
      run(1);
      check("t4_e_green", 32'(lights), 32'(green_l[2]));

      // 5: emergency preempts N, W served ahead of S/E, held past GREEN_MAX
      do_reset(4'b0001);
      run(4);
      check("t5_n_green_t1", 32'(lights), 32'(green_l[0]));
      bus.req = 4'b0110;
      bus.emerg_valid = 1'b1;
      bus.emerg_dir = 2'd3;
      run(1);
      check("t5_preempt_yellow", 32'(lights), 32'(yel_l[0]));
      run(2);
      check("t5_yellow_kept", 32'(lights), 32'(yel_l[0]));
      run(1);
      check("t5_allred", 32'(lights), 32'(L_AR));
      run(2);
      check("t5_allred_end", 32'(lights), 32'(L_AR));
      run(1);
      check("t5_w_green", 32'(lights), 32'(green_l[3]));
      check("t5_w_dir", 32'(bus.phase_dir), 32'd3);
      run(20);
      check("t5_w_hold", 32'(lights), 32'(green_l[3]));
      bus.emerg_valid = 1'b0;
      run(1);
      check("t5_release_gapout", 32'(lights), 32'(yel_l[3]));

      // 6: asynchronous reset mid-yellow, restart from N
      do_reset(4'b0001);
      run(3);
      bus.req = 4'b0100;
      run(5);
      check("t6_mid_yellow", 32'(lights), 32'(yel_l[0]));
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_lights", 32'(lights), 32'(L_AR));
      check("t6_async_state", 32'(bus.phase_state), 32'd0);
      bus.req = 4'b1111;
      run(1);
      rst = 1'b0;
      run(2);
      check("t6_restart_allred", 32'(lights), 32'(L_AR));
      run(1);
      check("t6_restart_n", 32'(lights), 32'(green_l[0]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
